// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter that shares one N-to-1 data mux and a single registered
// output stage among N_REQ valid/ready requesters. The requester that was just
// served drops to lowest priority. A continuously requesting source therefore
// waits at most N_REQ-1 transfers before it is served.
module mux_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       in_valid,
  input  logic [N_REQ*WIDTH-1:0] in_data,
  output logic [N_REQ-1:0]       in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  input  logic                   out_ready
);

  // Registered output stage and priority pointer
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [ID_W-1:0]  out_id_q,    out_id_d;
  logic [ID_W-1:0]  ptr_q,       ptr_d;

  // Arbitration results
  logic             load;
  logic             any;
  logic [ID_W-1:0]  winner;
  logic [WIDTH-1:0] winner_data;

  // The output stage can take a word when it is empty or is draining this cycle
  always_comb begin
    load = !out_valid_q || out_ready;
  end

  // Find the first valid requester at or after ptr, wrapping modulo N_REQ.
  // The scan runs from the farthest offset down to the nearest one, so the
  // last match written is the one closest to ptr.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    any    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (in_valid[idx]) begin
        winner = ID_W'(idx);
        any    = 1'b1;
      end
    end
  end

  // Shared N-to-1 data mux driven by the winner index
  always_comb begin
    winner_data = in_data[int'(winner)*WIDTH +: WIDTH];
  end

  // One-hot ready to the winner. It is suppressed during reset and while the
  // output stage is stalled.
  always_comb begin
    in_ready = '0;
    if (rst_n && load && any) begin
      in_ready[winner] = 1'b1;
    end
  end

  // Next-state logic. A transfer captures the winner and moves the pointer
  // just past it. The pointer wraps explicitly, so a non-power-of-two N_REQ
  // never leaves an unused encoding reachable.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = any;
      if (any) begin
        out_data_d = winner_data;
        out_id_d   = winner;
        if (int'(winner) == N_REQ - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = winner + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
// Directed scenarios followed by randomized traffic. Every cycle is compared
// against a behavioural model that keeps the priority pointer as a plain
// integer and finds the winner with a modulo scan.
module tb_mux_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = $clog2(N_REQ);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       in_valid;
  logic [N_REQ*WIDTH-1:0] in_data;
  logic [N_REQ-1:0]       in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_id;
  logic                   out_ready;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state
  logic             mValid;
  logic [WIDTH-1:0] mData;
  int               mId;
  int               mPtr;

  localparam logic [N_REQ*WIDTH-1:0] RR_DATA = 32'h3322_1100;

  mux_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // First valid index at or after p, wrapping modulo N_REQ; -1 when idle
  function automatic int findWinner(input logic [N_REQ-1:0] v, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  // Drives one cycle of inputs and compares all outputs mid-cycle. It then
  // advances the model across the rising edge and returns 1 time unit later.
  task automatic applyStimulus(input logic rstn, input logic [N_REQ-1:0] v,
                               input logic [N_REQ*WIDTH-1:0] d, input logic rdy);
    int win;
    logic load;
    logic [N_REQ-1:0] expReady;
    rst_n     = rstn;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(negedge clk);
    win  = findWinner(v, mPtr);
    load = !mValid || rdy;
    expReady = '0;
    if (rstn && load && win >= 0) expReady[win] = 1'b1;
    checkOutput("in_ready",  32'(in_ready),  32'(expReady));
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("out_data",  32'(out_data),  32'(mData));
    checkOutput("out_id",    32'(out_id),    32'(mId));
    @(posedge clk);
    if (!rstn) begin
      mValid = 1'b0;
      mData  = '0;
      mId    = 0;
      mPtr   = 0;
    end else if (load) begin
      mValid = (win >= 0);
      if (win >= 0) begin
        mData = d[win*WIDTH +: WIDTH];
        mId   = win;
        mPtr  = (win + 1) % N_REQ;
      end
    end
    #1;
  endtask

  initial begin
    int expIds [5] = '{0, 1, 2, 3, 0};
    logic [N_REQ-1:0] rv;
    logic [N_REQ*WIDTH-1:0] rd;

    rst_n     = 1'b0;
    in_valid  = '1;
    in_data   = RR_DATA;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    mValid = 1'b0; mData = '0; mId = 0; mPtr = 0;

    // Reset held two cycles with every requester asserting
    applyStimulus(1'b0, 4'b1111, RR_DATA, 1'b1);
    applyStimulus(1'b0, 4'b1111, RR_DATA, 1'b1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_id",    32'(out_id),    32'd0);

    // Round-robin sweep starting at requester 0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b1111, RR_DATA, 1'b1);
      checkOutput("rr_id",    32'(out_id),    32'(expIds[i]));
      checkOutput("rr_data",  32'(out_data),  32'(expIds[i] * 32'h11));
      checkOutput("rr_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure: buffer holds id 1 for three stalled cycles
    applyStimulus(1'b1, 4'b1111, RR_DATA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b1111, RR_DATA, 1'b0);
      checkOutput("bp_id",   32'(out_id),   32'd1);
      checkOutput("bp_data", 32'(out_data), 32'h11);
    end
    applyStimulus(1'b1, 4'b1111, RR_DATA, 1'b1);
    checkOutput("bp_next_id", 32'(out_id), 32'd2);

    // Sparse requests: move ptr to 2, then a lone requester 0, then 3 vs 0
    applyStimulus(1'b1, 4'b0010, RR_DATA, 1'b1);
    applyStimulus(1'b1, 4'b0001, RR_DATA, 1'b1);
    checkOutput("sparse_id0", 32'(out_id), 32'd0);
    applyStimulus(1'b1, 4'b1001, RR_DATA, 1'b1);
    checkOutput("sparse_id3", 32'(out_id), 32'd3);

    // Idle gaps: a lone requester 2 alternating with idle cycles
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 4'b0100, RR_DATA, 1'b1);
      checkOutput("gap_valid_hi", 32'(out_valid), 32'd1);
      checkOutput("gap_id",       32'(out_id),    32'd2);
      applyStimulus(1'b1, 4'b0000, RR_DATA, 1'b1);
      checkOutput("gap_valid_lo", 32'(out_valid), 32'd0);
      checkOutput("gap_id_hold",  32'(out_id),    32'd2);
    end
    applyStimulus(1'b1, 4'b1111, RR_DATA, 1'b1);
    checkOutput("gap_ptr3", 32'(out_id), 32'd3);

    // Reset mid-operation discards the stalled word and rewinds the pointer
    applyStimulus(1'b1, 4'b1111, RR_DATA, 1'b1);
    applyStimulus(1'b1, 4'b1111, RR_DATA, 1'b0);
    applyStimulus(1'b0, 4'b1111, RR_DATA, 1'b0);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 4'b1111, RR_DATA, 1'b1);
    checkOutput("midrst_id", 32'(out_id), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      rv = N_REQ'($urandom);
      rd = {$urandom};
      applyStimulus(($urandom_range(0, 99) != 0), rv, rd, ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
